// File: rtl/pl_stage_decode_if.sv
// Bus bundle for pl_stage_decode.
// Carries the stage control (en, start/done), the two byte-RAM read ports
// (compressed bytes, encoded-poly bytes) and the two coefficient write ports.
//   slave  : the decode stage itself
//   master : whoever drives it (previous stage, byte RAMs, next-stage RAMs)
interface pl_stage_decode_if;
  logic        en;
  logic        start_stage;
  logic        done_stage;
  logic [7:0]  baddr_c;
  logic [7:0]  bdo_c;
  logic [9:0]  baddr_p;
  logic [7:0]  bdo_p;
  logic        we_c;
  logic [8:0]  addr_c;
  logic [15:0] di_c;
  logic        we_p;
  logic [8:0]  addr_p;
  logic [15:0] di_p;

  modport slave (
    input  en, start_stage, bdo_c, bdo_p,
    output done_stage, baddr_c, baddr_p, we_c, addr_c, di_c, we_p, addr_p, di_p
  );

  modport master (
    output en, start_stage, bdo_c, bdo_p,
    input  done_stage, baddr_c, baddr_p, we_c, addr_c, di_c, we_p, addr_p, di_p
  );
endinterface

// File: rtl/pl_stage_decode.sv
// NewHope-512 receive-side stage: DecodePoly (896 B -> 512 x 14b) and
// Decompress (192 B -> 512 coefficients) running side by side.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : pl_stage_decode_if.slave (control, byte reads, coeff writes)
// Both engines share one group sequencer (pl_dec_engine): fetch K bytes,
// one wait cycle for the last byte, then emit M coefficients.

module pl_dec_engine #(
  parameter int K  = 7,
  parameter int M  = 4,
  parameter int G  = 128,
  parameter int AW = 10,
  localparam int KW = $clog2(K),
  localparam int JW = $clog2(M),
  localparam int GW = $clog2(G)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           go,
  input  logic [7:0]     bdo,
  output logic [AW-1:0]  baddr,
  output logic           idle,
  output logic           fin,
  output logic           emit,
  output logic [GW-1:0]  g,
  output logic [JW-1:0]  j,
  output logic [K*8-1:0] sr
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_EMIT, S_FIN} state_t;

  state_t        state, state_nx;
  logic [KW-1:0] k;
  logic [7:0]    sk;
  logic          sk_vld;
  logic [7:0]    byte_in;
  logic          cap;

  // The RAM keeps answering while we are frozen: the byte that was in flight
  // when en dropped is parked here and consumed on the first active cycle.
  assign byte_in = sk_vld ? sk : bdo;
  assign cap     = (state == S_FETCH && k != '0) || state == S_WAIT;

  assign idle = state == S_IDLE;
  assign fin  = state == S_FIN;
  assign emit = state == S_EMIT;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (go) state_nx = S_FETCH;
      S_FETCH: if (k == KW'(K-1)) state_nx = S_WAIT;
      S_WAIT:  state_nx = S_EMIT;
      S_EMIT:  if (j == JW'(M-1)) state_nx = (g == GW'(G-1)) ? S_FIN : S_FETCH;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      k      <= '0;
      j      <= '0;
      g      <= '0;
      baddr  <= '0;
      sr     <= '0;
      sk     <= '0;
      sk_vld <= 1'b0;
    end else if (!en) begin
      if (!sk_vld) begin
        sk     <= bdo;
        sk_vld <= 1'b1;
      end
    end else begin
      sk_vld <= 1'b0;
      state  <= state_nx;
      if (cap) sr <= {byte_in, sr[K*8-1:8]};
      case (state)
        S_IDLE: if (go) begin
          baddr <= '0;
          k     <= '0;
          j     <= '0;
          g     <= '0;
        end
        S_FETCH: begin
          // last byte address is held through WAIT/EMIT
          if (k == KW'(K-1)) k <= '0;
          else begin
            k     <= k + KW'(1);
            baddr <= baddr + AW'(1);
          end
        end
        S_EMIT: begin
          if (j == JW'(M-1)) begin
            j <= '0;
            g <= g + GW'(1);
            if (g != GW'(G-1)) baddr <= baddr + AW'(1);
          end else begin
            j <= j + JW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

module pl_stage_decode #(
  parameter int Q = 12289
) (
  input  logic clk,
  input  logic rst,
  pl_stage_decode_if.slave bus
);
  function automatic logic [7:0][15:0] mk_lut();
    for (int t = 0; t < 8; t++) mk_lut[t] = 16'((t * Q + 4) >> 3);
  endfunction
  localparam logic [7:0][15:0] DCMP_LUT = mk_lut();

  logic        en;
  logic        start_q, go;
  logic        flag_p, flag_c, done_q;
  logic        idle_p, idle_c, fin_p, fin_c, emit_p, emit_c;
  logic [6:0]  g_p;
  logic [1:0]  j_p;
  logic [5:0]  g_c;
  logic [2:0]  j_c;
  logic [55:0] sr_p;
  logic [23:0] sr_c;
  logic        we_p, we_c;
  logic [8:0]  addr_p, addr_c;
  logic [15:0] di_p, di_c;
  logic [2:0]  t_c;

  assign en = bus.en;
  assign go = start_q & idle_p & idle_c;

  pl_dec_engine #(.K(7), .M(4), .G(128), .AW(10)) u_dec (
    .clk(clk), .rst(rst), .en(en), .go(go), .bdo(bus.bdo_p), .baddr(bus.baddr_p),
    .idle(idle_p), .fin(fin_p), .emit(emit_p), .g(g_p), .j(j_p), .sr(sr_p)
  );

  pl_dec_engine #(.K(3), .M(8), .G(64), .AW(8)) u_dcmp (
    .clk(clk), .rst(rst), .en(en), .go(go), .bdo(bus.bdo_c), .baddr(bus.baddr_c),
    .idle(idle_c), .fin(fin_c), .emit(emit_c), .g(g_c), .j(j_c), .sr(sr_c)
  );

  // the shift register holds the group bytes little-endian, so both the
  // 14-bit decode fields and the 3-bit compressed fields are plain slices
  assign t_c = sr_c[int'(j_c)*3 +: 3];

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= 1'b0;
      flag_p  <= 1'b0;
      flag_c  <= 1'b0;
      done_q  <= 1'b0;
    end else if (!en) begin
      done_q  <= 1'b0;
    end else begin
      start_q <= bus.start_stage;
      if (go) begin
        flag_p <= 1'b0;
        flag_c <= 1'b0;
      end else begin
        flag_p <= flag_p | fin_p;
        flag_c <= flag_c | fin_c;
      end
      // pulse on the edge the second flag goes up
      done_q <= (flag_p | fin_p) & (flag_c | fin_c) & ~(flag_p & flag_c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_p   <= 1'b0;
      we_c   <= 1'b0;
      addr_p <= '0;
      addr_c <= '0;
      di_p   <= '0;
      di_c   <= '0;
    end else begin
      we_p <= en & emit_p;
      we_c <= en & emit_c;
      if (en && emit_p) begin
        addr_p <= {g_p, j_p};
        di_p   <= {2'b00, sr_p[int'(j_p)*14 +: 14]};
      end
      if (en && emit_c) begin
        addr_c <= {g_c, j_c};
        di_c   <= DCMP_LUT[t_c];
      end
    end
  end

  assign bus.done_stage = done_q;
  assign bus.we_p       = we_p;
  assign bus.addr_p     = addr_p;
  assign bus.di_p       = di_p;
  assign bus.we_c       = we_c;
  assign bus.addr_c     = addr_c;
  assign bus.di_c       = di_c;
endmodule
